// File: rtl/pong_score_keeper_pkg.sv
// Shared encodings and constants for the pong score keeper.
package pong_score_keeper_pkg;

  localparam int unsigned DIGIT_W           = 4;
  localparam logic [DIGIT_W-1:0] FLASH_CODE = 4'hF;
  localparam int unsigned DEFAULT_WIN_SCORE = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  function automatic logic [6:0] bcd_to_bin(input logic [DIGIT_W-1:0] tens,
                                            input logic [DIGIT_W-1:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/pong_score_keeper_bcd_pair_counter.sv
// Two-digit BCD score counter, saturating at 99, with registered flags for
// "score equals WIN_SCORE" and "one point short of WIN_SCORE".
module bcd_pair_counter
  import pong_score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE = DEFAULT_WIN_SCORE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [DIGIT_W-1:0] o_tens,
  output logic [DIGIT_W-1:0] o_ones,
  output logic               o_at_win,
  output logic               o_one_short
);

  logic [DIGIT_W-1:0] r_tens, r_ones;
  logic [DIGIT_W-1:0] w_next_tens, w_next_ones;
  logic               r_at_win, r_one_short;
  logic [6:0]         w_next_bin;

  always_comb begin
    w_next_tens = r_tens;
    w_next_ones = r_ones;
    if (i_clr) begin
      w_next_tens = '0;
      w_next_ones = '0;
    end else if (i_inc && !(r_tens == 4'd9 && r_ones == 4'd9)) begin
      if (r_ones == 4'd9) begin
        w_next_ones = '0;
        w_next_tens = r_tens + 4'd1;
      end else begin
        w_next_ones = r_ones + 4'd1;
      end
    end
  end

  assign w_next_bin = bcd_to_bin(w_next_tens, w_next_ones);

  // Flags track the next value so the FSM sees them aligned with the digits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tens      <= '0;
      r_ones      <= '0;
      r_at_win    <= 1'b0;
      r_one_short <= (WIN_SCORE == 1);
    end else begin
      r_tens      <= w_next_tens;
      r_ones      <= w_next_ones;
      r_at_win    <= (w_next_bin == 7'(WIN_SCORE));
      r_one_short <= (w_next_bin == 7'(WIN_SCORE - 1));
    end
  end

  assign o_tens      = r_tens;
  assign o_ones      = r_ones;
  assign o_at_win    = r_at_win;
  assign o_one_short = r_one_short;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong match sequencer and two-player BCD score keeper.
// Optional SCORE_FLASH_EN: winner's digits flash 4'hF while in OVER.
module pong_score_keeper
  import pong_score_keeper_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int unsigned SERVE_DELAY  = 100_000_000,
  parameter int unsigned FLASH_PERIOD = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StartGame,
  input  logic               Point1,
  input  logic               Point2,
  output logic [DIGIT_W-1:0] P1Tens,
  output logic [DIGIT_W-1:0] P1Ones,
  output logic [DIGIT_W-1:0] P2Tens,
  output logic [DIGIT_W-1:0] P2Ones,
  output logic               ServeEnable,
  output logic [1:0]         Winner,
  output logic [1:0]         GameState
);

  localparam int unsigned SCW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  if (WIN_SCORE < 1 || WIN_SCORE > 99 || SERVE_DELAY < 1 || FLASH_PERIOD < 1) begin : g_param_check
    $error("pong_score_keeper: illegal parameter value");
  end

  logic               r_start_d, r_p1_d, r_p2_d;
  logic               w_start_edge, w_p1_edge, w_p2_edge;
  logic               w_p1_inc, w_p2_inc;
  game_state_t        r_state;
  winner_t            r_winner;
  logic               r_serve_en;
  logic [SCW-1:0]     r_serve_cnt;
  logic [DIGIT_W-1:0] w_p1_tens, w_p1_ones, w_p2_tens, w_p2_ones;
  logic               w_p1_at_win, w_p2_at_win, w_p1_one_short, w_p2_one_short;

  assign w_start_edge = StartGame & ~r_start_d;
  assign w_p1_edge    = Point1 & ~r_p1_d;
  assign w_p2_edge    = Point2 & ~r_p2_d;
  assign w_p1_inc     = (r_state == ST_PLAY) & w_p1_edge & ~w_p2_edge & ~w_start_edge;
  assign w_p2_inc     = (r_state == ST_PLAY) & w_p2_edge & ~w_p1_edge & ~w_start_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_d <= 1'b0;
      r_p1_d    <= 1'b0;
      r_p2_d    <= 1'b0;
    end else begin
      r_start_d <= StartGame;
      r_p1_d    <= Point1;
      r_p2_d    <= Point2;
    end
  end

  bcd_pair_counter #(.WIN_SCORE(WIN_SCORE)) u_p1 (
    .i_clk(clk), .i_rst_n(reset), .i_inc(w_p1_inc), .i_clr(w_start_edge),
    .o_tens(w_p1_tens), .o_ones(w_p1_ones),
    .o_at_win(w_p1_at_win), .o_one_short(w_p1_one_short)
  );

  bcd_pair_counter #(.WIN_SCORE(WIN_SCORE)) u_p2 (
    .i_clk(clk), .i_rst_n(reset), .i_inc(w_p2_inc), .i_clr(w_start_edge),
    .o_tens(w_p2_tens), .o_ones(w_p2_ones),
    .o_at_win(w_p2_at_win), .o_one_short(w_p2_one_short)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_winner    <= WIN_NONE;
      r_serve_en  <= 1'b0;
      r_serve_cnt <= '0;
    end else begin
      r_serve_en <= 1'b0;
      if (w_start_edge) begin
        r_state     <= ST_SERVE;
        r_serve_cnt <= '0;
        r_winner    <= WIN_NONE;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_SERVE: begin
            if (r_serve_cnt == SCW'(SERVE_DELAY - 1)) begin
              r_state     <= ST_PLAY;
              r_serve_cnt <= '0;
              r_serve_en  <= 1'b1;
            end else begin
              r_serve_cnt <= r_serve_cnt + 1'b1;
            end
          end
          ST_PLAY: begin
            // one_short means this increment lands exactly on WIN_SCORE
            if (w_p1_inc && w_p1_one_short) begin
              r_state  <= ST_OVER;
              r_winner <= WIN_P1;
            end else if (w_p2_inc && w_p2_one_short) begin
              r_state  <= ST_OVER;
              r_winner <= WIN_P2;
            end else if (w_p1_edge || w_p2_edge) begin
              r_state     <= ST_SERVE;
              r_serve_cnt <= '0;
            end else begin
              r_serve_en <= 1'b1;
            end
          end
          ST_OVER: r_winner <= winner_t'({w_p2_at_win, w_p1_at_win});
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ServeEnable = r_serve_en;
  assign Winner      = r_winner;
  assign GameState   = r_state;

`ifdef SCORE_FLASH_EN
  localparam int unsigned FCW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

  logic [FCW-1:0] r_flash_cnt;
  logic           r_phase;
  logic           w_p1_flash, w_p2_flash;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flash_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_state != ST_OVER || w_start_edge) begin
      r_flash_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_flash_cnt == FCW'(FLASH_PERIOD - 1)) begin
      r_flash_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_flash_cnt <= r_flash_cnt + 1'b1;
    end
  end

  assign w_p1_flash = r_phase && (r_winner == WIN_P1);
  assign w_p2_flash = r_phase && (r_winner == WIN_P2);
  assign P1Tens = w_p1_flash ? FLASH_CODE : w_p1_tens;
  assign P1Ones = w_p1_flash ? FLASH_CODE : w_p1_ones;
  assign P2Tens = w_p2_flash ? FLASH_CODE : w_p2_tens;
  assign P2Ones = w_p2_flash ? FLASH_CODE : w_p2_ones;
`else
  assign P1Tens = w_p1_tens;
  assign P1Ones = w_p1_ones;
  assign P2Tens = w_p2_tens;
  assign P2Ones = w_p2_ones;
`endif

endmodule

// File: tb/tb_pong_score_keeper.sv
// Directed self-checking bench for pong_score_keeper (SERVE_DELAY=4, FLASH_PERIOD=3, WIN_SCORE=11).
module tb_pong_score_keeper;

  logic       clk = 1'b0;
  logic       reset, StartGame, Point1, Point2;
  logic [3:0] P1Tens, P1Ones, P2Tens, P2Ones;
  logic       ServeEnable;
  logic [1:0] Winner, GameState;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pong_score_keeper #(.WIN_SCORE(11), .SERVE_DELAY(4), .FLASH_PERIOD(3)) dut (
    .clk(clk), .reset(reset), .StartGame(StartGame), .Point1(Point1), .Point2(Point2),
    .P1Tens(P1Tens), .P1Ones(P1Ones), .P2Tens(P2Tens), .P2Ones(P2Ones),
    .ServeEnable(ServeEnable), .Winner(Winner), .GameState(GameState)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] st, input logic se, input logic [1:0] win);
    chk({tag, ".state"}, 8'(GameState), 8'(st));
    chk({tag, ".serve"}, 8'(ServeEnable), 8'(se));
    chk({tag, ".winner"}, 8'(Winner), 8'(win));
  endtask

  task automatic chk_scores(input string tag, input logic [3:0] p1t, input logic [3:0] p1o,
                            input logic [3:0] p2t, input logic [3:0] p2o);
    chk({tag, ".p1t"}, 8'(P1Tens), 8'(p1t));
    chk({tag, ".p1o"}, 8'(P1Ones), 8'(p1o));
    chk({tag, ".p2t"}, 8'(P2Tens), 8'(p2t));
    chk({tag, ".p2o"}, 8'(P2Ones), 8'(p2o));
  endtask

  // Called right after SERVE is entered: three more SERVE cycles, then PLAY.
  task automatic serve_to_play(input string tag);
    repeat (3) begin
      tick;
      chk({tag, ".serving"}, 8'(GameState), 8'd1);
    end
    tick;
    chk({tag, ".play"}, 8'(GameState), 8'd2);
    chk({tag, ".serve_en"}, 8'(ServeEnable), 8'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; StartGame = 1'b0; Point1 = 1'b0; Point2 = 1'b0;
    repeat (2) tick;
    chk_state("rst", 2'd0, 1'b0, 2'b00);
    chk_scores("rst", 4'd0, 4'd0, 4'd0, 4'd0);
    reset = 1'b1;
    tick;
    chk_state("idle", 2'd0, 1'b0, 2'b00);

    StartGame = 1'b1; tick; StartGame = 1'b0;
    chk_state("start", 2'd1, 1'b0, 2'b00);
    serve_to_play("start");
    chk_scores("start", 4'd0, 4'd0, 4'd0, 4'd0);

    Point1 = 1'b1; tick;
    chk_scores("hold1", 4'd0, 4'd1, 4'd0, 4'd0);
    chk_state("hold1", 2'd1, 1'b0, 2'b00);
    repeat (9) tick;
    Point1 = 1'b0;
    chk_scores("hold10", 4'd0, 4'd1, 4'd0, 4'd0);
    chk_state("hold10", 2'd2, 1'b1, 2'b00);
    tick;

    for (int i = 2; i <= 10; i++) begin
      Point1 = 1'b1; tick; Point1 = 1'b0;
      chk("p1run.t", 8'(P1Tens), 8'(i / 10));
      chk("p1run.o", 8'(P1Ones), 8'(i % 10));
      chk("p1run.state", 8'(GameState), 8'd1);
      serve_to_play("p1run");
    end
    chk_scores("ten", 4'd1, 4'd0, 4'd0, 4'd0);

    Point1 = 1'b1; Point2 = 1'b1; tick; Point1 = 1'b0; Point2 = 1'b0;
    chk_scores("both", 4'd1, 4'd0, 4'd0, 4'd0);
    chk_state("both", 2'd1, 1'b0, 2'b00);
    serve_to_play("both");

    Point1 = 1'b1; tick; Point1 = 1'b0;
    chk_scores("win", 4'd1, 4'd1, 4'd0, 4'd0);
    chk_state("win", 2'd3, 1'b0, 2'b01);

`ifdef SCORE_FLASH_EN
    repeat (2) begin
      tick;
      chk("flash.on.o", 8'(P1Ones), 8'h01);
    end
    repeat (3) begin
      tick;
      chk("flash.f.t", 8'(P1Tens), 8'h0F);
      chk("flash.f.o", 8'(P1Ones), 8'h0F);
      chk("flash.loser", 8'(P2Ones), 8'h00);
    end
    tick;
    chk("flash.back.t", 8'(P1Tens), 8'h01);
    chk("flash.back.o", 8'(P1Ones), 8'h01);
`endif

    Point2 = 1'b1; tick; Point2 = 1'b0;
    chk_scores("over_pt", 4'd1, 4'd1, 4'd0, 4'd0);
    chk_state("over_pt", 2'd3, 1'b0, 2'b01);

    StartGame = 1'b1; tick; StartGame = 1'b0;
    chk_scores("restart", 4'd0, 4'd0, 4'd0, 4'd0);
    chk_state("restart", 2'd1, 1'b0, 2'b00);
    serve_to_play("restart");

    Point2 = 1'b1; tick; Point2 = 1'b0;
    chk_scores("p2pt", 4'd0, 4'd0, 4'd0, 4'd1);
    chk_state("p2pt", 2'd1, 1'b0, 2'b00);

    Point1 = 1'b1; tick; Point1 = 1'b0;
    chk_scores("serve_pt", 4'd0, 4'd0, 4'd0, 4'd1);

    #2 reset = 1'b0;
    #1;
    chk_scores("async", 4'd0, 4'd0, 4'd0, 4'd0);
    chk_state("async", 2'd0, 1'b0, 2'b00);
    tick;
    reset = 1'b1;
    tick;

    Point1 = 1'b1; tick; Point1 = 1'b0;
    chk_scores("idle_pt", 4'd0, 4'd0, 4'd0, 4'd0);
    chk("idle_pt.state", 8'(GameState), 8'd0);

    StartGame = 1'b1; tick; StartGame = 1'b0;
    serve_to_play("prio");
    Point2 = 1'b1; tick; Point2 = 1'b0;
    chk("prio.p2", 8'(P2Ones), 8'd1);
    serve_to_play("prio2");
    StartGame = 1'b1; Point1 = 1'b1; tick; StartGame = 1'b0; Point1 = 1'b0;
    chk_scores("prio", 4'd0, 4'd0, 4'd0, 4'd0);
    chk_state("prio", 2'd1, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_score_keeper.md
Name: pong_score_keeper

Overview:
- Upstream feeder of the on-screen score digits.
- Counts points for two players as two-digit BCD scores and sequences the match: idle, serve delay, play, game over.
- Drives the 4-bit Value input of four seven-segment glyph renderers: P1 tens/ones and P2 tens/ones.
- Gates ball launch via ServeEnable; declares the winner.

Parameters:
- WIN_SCORE, 11: points needed to win. Legal range 1..99.
- SERVE_DELAY, 100_000_000: cycles spent in SERVE before play resumes; >= 1.
- FLASH_PERIOD, 25_000_000: half-period of the winner-digit flash, in cycles. Used only with SCORE_FLASH_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- StartGame  in  1  level from debounced button; rising edge starts or restarts a match
- Point1  in  1  level from ball logic; rising edge = point for player 1
- Point2  in  1  level from ball logic; rising edge = point for player 2
- P1Tens  out  4  player 1 tens digit, BCD
- P1Ones  out  4  player 1 ones digit, BCD
- P2Tens  out  4  player 2 tens digit, BCD
- P2Ones  out  4  player 2 ones digit, BCD
- ServeEnable  out  1  high only in PLAY; ball may move
- Winner  out  2  00 none, 01 P1, 10 P2
- GameState  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

Behaviour:
- Reset (reset==0, asynchronous):
  - all digits 0; state IDLE; ServeEnable 0; Winner 00; flash phase 0.
  - Edge-detect registers cleared to 0.
  - Reset mid-match discards all scores immediately.
- Inputs are synchronous to clk.
- Edge detection:
  - Each of StartGame/Point1/Point2 has a delayed copy x_d; edge = x & ~x_d.
  - An input held high counts once.
  - Effects are visible on outputs the cycle after the edge is sampled (1-cycle latency).
- FSM:
  - IDLE: outputs 0. Start edge -> SERVE, delay counter cleared.
  - SERVE: counter increments each cycle. At SERVE_DELAY-1 -> PLAY, counter cleared. Point edges ignored.
  - PLAY: ServeEnable=1.
    - Point1 edge alone: P1 += 1.
    - Point2 edge alone: P2 += 1.
    - After an increment: if the new score == WIN_SCORE -> OVER with Winner set in the same update; else -> SERVE.
    - Both edges in the same cycle: let. No score change -> SERVE.
  - OVER: scores and Winner held; ServeEnable 0; point edges ignored.
  - Start edge in SERVE, PLAY or OVER: clear digits and Winner -> SERVE. Start takes priority over a simultaneous point edge.
- BCD increment:
  - Ones 9 -> 0 with tens += 1.
  - Score saturates at 99; no wrap to 00.
- Digits are always in 0..9, except the flash code below.
- ServeEnable, Winner and GameState are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SCORE_FLASH_EN.
- Defined:
  - In OVER, a FLASH_PERIOD counter toggles a phase bit.
  - While phase=1, the winner's two digit outputs read 4'hF (non-digit code); the stored score is unchanged.
  - Phase and counter clear on leaving OVER and on reset.
- Undefined: no counter or phase logic; digits always show the stored score.

Decomposition:
- Shared pong package/header: GameState encodings; Winner encodings; BCD digit width (4); flash code 4'hF; default WIN_SCORE.
- Sub-module bcd_pair_counter (one per player):
  - Inputs: inc, clr.
  - Outputs: tens, ones, and a registered equality flag vs WIN_SCORE.
  - Saturating at 99.

Test Plan (SERVE_DELAY=4, FLASH_PERIOD=3, WIN_SCORE=11):
- Reset then Start pulse -> GameState 1 for 4 cycles, then 2 with ServeEnable=1; all digits 0.
- In PLAY, Point1 held high 10 cycles -> P1Ones=1 exactly once; state -> SERVE; ServeEnable=0.
- Ten P1 points, each after its serve delay -> P1Tens=1, P1Ones=0. Eleventh point -> P1Ones=1, GameState=3, Winner=01, ServeEnable=0.
- Point1 and Point2 rise in the same cycle in PLAY -> scores unchanged; state SERVE.
- In OVER, Point2 edge -> ignored. Start edge -> digits 0, Winner 00, SERVE.
- reset driven low mid-SERVE, asynchronously between clocks -> outputs zero before the next clk edge.
- With SCORE_FLASH_EN: in OVER, winner digits alternate stored value / 4'hF every 3 cycles; loser digits steady.
